biriscv_mul_arbiter: RTL and testbench

// Shares the single pipelined multiplier between the two issue pipes of the

---
 rtl/biriscv_mul_arbiter_if.sv | 61 ++++++
 rtl/biriscv_mul_arbiter.sv | 122 ++++++++++++
 tb/tb_biriscv_mul_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_mul_arbiter_if.sv
// biriscv_mul_arbiter_if
//
// Bundles the request side of both issue pipes, the stall/flush controls and
// everything the arbiter drives back. The multiplier-facing signals and the
// writeback tag are carried here as well, so that one connection wires up the
// whole arbiter.
//
//   master : pipe/control side. It drives the requests, hold_i and flush_i, and
//            observes the accepts, the multiplier feed and the writeback tag.
//   slave  : the arbiter itself.
//
// Signals
//   req{0,1}_valid_i, _opcode_i, _rd_idx_i, _ra_operand_i, _rb_operand_i
//   hold_i, flush_i
//   req{0,1}_accept_o
//   mul_valid_o, mul_opcode_o, mul_ra_operand_o, mul_rb_operand_o, mul_hold_o
//   wb_valid_o, wb_pipe_o, wb_rd_idx_o, inflight_o
interface biriscv_mul_arbiter_if;
  logic        req0_valid_i;
  logic [31:0] req0_opcode_i;
  logic [4:0]  req0_rd_idx_i;
  logic [31:0] req0_ra_operand_i;
  logic [31:0] req0_rb_operand_i;
  logic        req1_valid_i;
  logic [31:0] req1_opcode_i;
  logic [4:0]  req1_rd_idx_i;
  logic [31:0] req1_ra_operand_i;
  logic [31:0] req1_rb_operand_i;
  logic        hold_i;
  logic        flush_i;

  logic        req0_accept_o;
  logic        req1_accept_o;
  logic        mul_valid_o;
  logic [31:0] mul_opcode_o;
  logic [31:0] mul_ra_operand_o;
  logic [31:0] mul_rb_operand_o;
  logic        mul_hold_o;
  logic        wb_valid_o;
  logic        wb_pipe_o;
  logic [4:0]  wb_rd_idx_o;
  logic [1:0]  inflight_o;

  modport master (
    output req0_valid_i, req0_opcode_i, req0_rd_idx_i, req0_ra_operand_i, req0_rb_operand_i,
    output req1_valid_i, req1_opcode_i, req1_rd_idx_i, req1_ra_operand_i, req1_rb_operand_i,
    output hold_i, flush_i,
    input  req0_accept_o, req1_accept_o,
    input  mul_valid_o, mul_opcode_o, mul_ra_operand_o, mul_rb_operand_o, mul_hold_o,
    input  wb_valid_o, wb_pipe_o, wb_rd_idx_o, inflight_o
  );

  modport slave (
    input  req0_valid_i, req0_opcode_i, req0_rd_idx_i, req0_ra_operand_i, req0_rb_operand_i,
    input  req1_valid_i, req1_opcode_i, req1_rd_idx_i, req1_ra_operand_i, req1_rb_operand_i,
    input  hold_i, flush_i,
    output req0_accept_o, req1_accept_o,
    output mul_valid_o, mul_opcode_o, mul_ra_operand_o, mul_rb_operand_o, mul_hold_o,
    output wb_valid_o, wb_pipe_o, wb_rd_idx_o, inflight_o
  );
endinterface

// File: rtl/biriscv_mul_arbiter.sv
// biriscv_mul_arbiter
//
// Shares the single pipelined multiplier between the two issue pipes. At most
// one multiply request is granted per cycle. When both pipes ask at once, the
// grant alternates between them (round-robin). A tag pipeline that is
// MULT_STAGES deep travels alongside each op, so that the multiplier result
// can be labelled with its issuing pipe and its rd.
//
// Ports
//   clk_i  : clock
//   rst_i  : asynchronous reset, active-high
//   bus    : biriscv_mul_arbiter_if.slave. It carries the requests, hold/flush,
//            the accepts, the multiplier feed and the writeback tag.
//
// Parameter
//   MULT_STAGES : issue->result latency of the multiplier (2 or 3)
module biriscv_mul_arbiter #(
  parameter int MULT_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  biriscv_mul_arbiter_if.slave     bus
);

  logic                        rr_q, rr_d;
  logic [MULT_STAGES-1:0]      tag_valid_q, tag_valid_d;
  logic [MULT_STAGES-1:0]      tag_pipe_q, tag_pipe_d;
  logic [MULT_STAGES-1:0][4:0] tag_rd_q, tag_rd_d;
  logic [1:0]                  inflight_q, inflight_d;

  logic        can_grant;
  logic        grant0, grant1, grant, granted_pipe;
  logic [4:0]  granted_rd;
  logic [31:0] mul_opcode, mul_ra, mul_rb;

  function automatic logic [1:0] popcount(input logic [MULT_STAGES-1:0] v);
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int i = 0; i < MULT_STAGES; i++) cnt = cnt + {1'b0, v[i]};
    return cnt;
  endfunction

  // Grant selection. rr_q names the pipe that wins the next contended cycle.
  always_comb begin
    can_grant    = ~bus.hold_i & ~bus.flush_i;
    grant0       = can_grant & bus.req0_valid_i & (~bus.req1_valid_i | ~rr_q);
    grant1       = can_grant & bus.req1_valid_i & (~bus.req0_valid_i |  rr_q);
    grant        = grant0 | grant1;
    granted_pipe = grant1;
    rr_d         = grant ? ~granted_pipe : rr_q;
  end

  // Multiplier feed. It is held at zero when nothing is granted.
  always_comb begin
    mul_opcode = 32'd0;
    mul_ra     = 32'd0;
    mul_rb     = 32'd0;
    granted_rd = 5'd0;
    if (grant0) begin
      mul_opcode = bus.req0_opcode_i;
      mul_ra     = bus.req0_ra_operand_i;
      mul_rb     = bus.req0_rb_operand_i;
      granted_rd = bus.req0_rd_idx_i;
    end else if (grant1) begin
      mul_opcode = bus.req1_opcode_i;
      mul_ra     = bus.req1_ra_operand_i;
      mul_rb     = bus.req1_rb_operand_i;
      granted_rd = bus.req1_rd_idx_i;
    end
  end

  // Tag pipeline next state. It shifts in step with the multiplier and freezes
  // while the multiplier is held. A flush clears the valids even while held,
  // but it moves nothing, so the pipe/rd fields stay put.
  always_comb begin
    tag_valid_d = tag_valid_q;
    tag_pipe_d  = tag_pipe_q;
    tag_rd_d    = tag_rd_q;
    if (!bus.hold_i) begin
      for (int i = 1; i < MULT_STAGES; i++) begin
        tag_valid_d[i] = tag_valid_q[i-1];
        tag_pipe_d[i]  = tag_pipe_q[i-1];
        tag_rd_d[i]    = tag_rd_q[i-1];
      end
      tag_valid_d[0] = grant;
      tag_pipe_d[0]  = granted_pipe;
      tag_rd_d[0]    = granted_rd;
    end
    if (bus.flush_i) tag_valid_d = '0;
    inflight_d = popcount(tag_valid_d);
  end

  // Stage boundary: arbiter state and tag pipeline registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= 1'b0;
      tag_valid_q <= '0;
      tag_pipe_q  <= '0;
      tag_rd_q    <= '0;
      inflight_q  <= 2'd0;
    end else begin
      rr_q        <= rr_d;
      tag_valid_q <= tag_valid_d;
      tag_pipe_q  <= tag_pipe_d;
      tag_rd_q    <= tag_rd_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus.req0_accept_o    = grant0;
  assign bus.req1_accept_o    = grant1;
  assign bus.mul_valid_o      = grant;
  assign bus.mul_opcode_o     = mul_opcode;
  assign bus.mul_ra_operand_o = mul_ra;
  assign bus.mul_rb_operand_o = mul_rb;
  assign bus.mul_hold_o       = bus.hold_i;
  assign bus.wb_valid_o       = tag_valid_q[MULT_STAGES-1];
  assign bus.wb_pipe_o        = tag_pipe_q[MULT_STAGES-1];
  assign bus.wb_rd_idx_o      = tag_rd_q[MULT_STAGES-1];
  assign bus.inflight_o       = inflight_q;

endmodule

// File: tb/tb_biriscv_mul_arbiter.sv
module tb_biriscv_mul_arbiter;

  localparam logic [31:0] OP0 = 32'h0231_00b3;  // mul x1,x2,x3
  localparam logic [31:0] OP1 = 32'h0253_1233;  // mulh x4,x6,x5
  localparam logic [31:0] RA0 = 32'd3;
  localparam logic [31:0] RB0 = 32'd7;
  localparam logic [31:0] RA1 = 32'd11;
  localparam logic [31:0] RB1 = 32'd13;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  biriscv_mul_arbiter_if bus();

  biriscv_mul_arbiter #(.MULT_STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v0, v1, hold, flush;
    logic a0, a1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic v1,
                       input logic [4:0] rd1, input logic hold, input logic flush);
    bus.req0_valid_i  = v0;
    bus.req0_rd_idx_i = rd0;
    bus.req1_valid_i  = v1;
    bus.req1_rd_idx_i = rd1;
    bus.hold_i        = hold;
    bus.flush_i       = flush;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_wb_valid", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("rst_wb_pipe",  {31'd0, bus.wb_pipe_o}, 32'd0);
    chk("rst_wb_rd",    {27'd0, bus.wb_rd_idx_o}, 32'd0);
    chk("rst_inflight", {30'd0, bus.inflight_o}, 32'd0);
    rst = 1'b0;
  endtask

  // Check one writeback tag sample
  task automatic chk_wb(input string nm, input logic v, input logic p,
                        input logic [4:0] rd, input logic [1:0] inf);
    chk({nm, "_wb_valid"}, {31'd0, bus.wb_valid_o}, {31'd0, v});
    if (v) begin
      chk({nm, "_wb_pipe"}, {31'd0, bus.wb_pipe_o}, {31'd0, p});
      chk({nm, "_wb_rd"},   {27'd0, bus.wb_rd_idx_o}, {27'd0, rd});
    end
    chk({nm, "_inflight"}, {30'd0, bus.inflight_o}, {30'd0, inf});
  endtask

  task automatic chk_acc(input string nm, input logic a0, input logic a1);
    chk({nm, "_acc0"}, {31'd0, bus.req0_accept_o}, {31'd0, a0});
    chk({nm, "_acc1"}, {31'd0, bus.req1_accept_o}, {31'd0, a1});
  endtask

  initial begin
    logic [31:0] exp_op, exp_ra, exp_rb;
    logic [1:0]  peak;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req0_opcode_i     = OP0;
    bus.req0_ra_operand_i = RA0;
    bus.req0_rb_operand_i = RB0;
    bus.req1_opcode_i     = OP1;
    bus.req1_ra_operand_i = RA1;
    bus.req1_rb_operand_i = RB1;
    idle();

    // Grant table, applied cycle by cycle from reset (rr starts at pipe0)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    reset_dut();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, 5'd9, vecs[i].v1, 5'd17, vecs[i].hold, vecs[i].flush);
      #1;
      exp_op = vecs[i].a0 ? OP0 : (vecs[i].a1 ? OP1 : 32'd0);
      exp_ra = vecs[i].a0 ? RA0 : (vecs[i].a1 ? RA1 : 32'd0);
      exp_rb = vecs[i].a0 ? RB0 : (vecs[i].a1 ? RB1 : 32'd0);
      chk_acc($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1);
      chk($sformatf("vec%0d_mul_valid", i), {31'd0, bus.mul_valid_o}, {31'd0, vecs[i].a0 | vecs[i].a1});
      chk($sformatf("vec%0d_mul_opcode", i), bus.mul_opcode_o, exp_op);
      chk($sformatf("vec%0d_mul_ra", i), bus.mul_ra_operand_o, exp_ra);
      chk($sformatf("vec%0d_mul_rb", i), bus.mul_rb_operand_o, exp_rb);
      chk($sformatf("vec%0d_mul_hold", i), {31'd0, bus.mul_hold_o}, {31'd0, vecs[i].hold});
    end

    // Single op: pipe0 rd=5, result tag at N+2 only
    reset_dut();
    @(negedge clk); drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk_acc("single_n", 1'b1, 1'b0);
    chk_wb("single_n", 1'b0, 1'b0, 5'd0, 2'd0);
    @(negedge clk); idle(); #1;
    chk_wb("single_n1", 1'b0, 1'b0, 5'd0, 2'd1);
    @(negedge clk); #1;
    chk_wb("single_n2", 1'b1, 1'b0, 5'd5, 2'd1);
    @(negedge clk); #1;
    chk_wb("single_n3", 1'b0, 1'b0, 5'd0, 2'd0);

    // Contention x4 after reset: grants 0,1,0,1 and results in the same order
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) drive(1'b1, 5'd10, 1'b1, 5'd20, 1'b0, 1'b0);
      else idle();
      #1;
      if (c < 4) chk_acc($sformatf("cont%0d", c), (c % 2) == 0, (c % 2) == 1);
      if (c >= 2)
        chk_wb($sformatf("cont%0d", c), 1'b1, ((c - 2) % 2) == 1,
               ((c - 2) % 2) == 1 ? 5'd20 : 5'd10, (c == 5) ? 2'd1 : 2'd2);
      else
        chk_wb($sformatf("cont%0d", c), 1'b0, 1'b0, 5'd0, (c == 0) ? 2'd0 : 2'd1);
    end

    // Back-to-back from pipe1, rd=1,2,3
    @(negedge clk); idle(); #1;
    peak = 2'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 3) drive(1'b0, 5'd0, 1'b1, 5'(c + 1), 1'b0, 1'b0);
      else idle();
      #1;
      if (bus.inflight_o > peak) peak = bus.inflight_o;
      if (c < 3) chk_acc($sformatf("b2b%0d", c), 1'b0, 1'b1);
      case (c)
        0: chk_wb("b2b0", 1'b0, 1'b0, 5'd0, 2'd0);
        1: chk_wb("b2b1", 1'b0, 1'b0, 5'd0, 2'd1);
        2: chk_wb("b2b2", 1'b1, 1'b1, 5'd1, 2'd2);
        3: chk_wb("b2b3", 1'b1, 1'b1, 5'd2, 2'd2);
        4: chk_wb("b2b4", 1'b1, 1'b1, 5'd3, 2'd1);
        default: chk_wb("b2b5", 1'b0, 1'b0, 5'd0, 2'd0);
      endcase
    end
    chk("b2b_peak", {30'd0, peak}, 32'd2);

    // Hold for 3 cycles with two ops in flight
    @(negedge clk); drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk_acc("hold_n", 1'b1, 1'b0);
    @(negedge clk); drive(1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0); #1;
    chk_acc("hold_n1", 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0); #1;
      chk_acc($sformatf("hold_h%0d", c), 1'b0, 1'b0);
      chk($sformatf("hold_h%0d_mul_valid", c), {31'd0, bus.mul_valid_o}, 32'd0);
      chk_wb($sformatf("hold_h%0d", c), 1'b1, 1'b0, 5'd7, 2'd2);
    end
    @(negedge clk); idle(); #1;
    chk_wb("hold_r0", 1'b1, 1'b0, 5'd7, 2'd2);
    @(negedge clk); #1;
    chk_wb("hold_r1", 1'b1, 1'b1, 5'd8, 2'd1);
    @(negedge clk); #1;
    chk_wb("hold_r2", 1'b0, 1'b0, 5'd0, 2'd0);

    // Flush one cycle after a contended grant
    reset_dut();
    @(negedge clk); drive(1'b1, 5'd12, 1'b1, 5'd13, 1'b0, 1'b0); #1;
    chk_acc("flush_n", 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 5'd12, 1'b1, 5'd13, 1'b0, 1'b1); #1;
    chk_acc("flush_n1", 1'b0, 1'b0);
    chk("flush_n1_mul_valid", {31'd0, bus.mul_valid_o}, 32'd0);
    chk_wb("flush_n1", 1'b0, 1'b0, 5'd0, 2'd1);
    @(negedge clk); idle(); #1;
    chk_wb("flush_n2", 1'b0, 1'b0, 5'd0, 2'd0);
    @(negedge clk); #1;
    chk_wb("flush_n3", 1'b0, 1'b0, 5'd0, 2'd0);

    // Asynchronous reset mid-clock with two in flight, rr left pointing at pipe1
    reset_dut();
    @(negedge clk); drive(1'b0, 5'd0, 1'b1, 5'd21, 1'b0, 1'b0); #1;
    chk_acc("arst_n", 1'b0, 1'b1);
    @(negedge clk); drive(1'b1, 5'd22, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk_acc("arst_n1", 1'b1, 1'b0);
    @(negedge clk); idle(); #1;
    chk_wb("arst_pre", 1'b1, 1'b1, 5'd21, 2'd2);
    rst = 1'b1;
    #1;
    chk_wb("arst_during", 1'b0, 1'b0, 5'd0, 2'd0);
    rst = 1'b0;
    #1;
    @(negedge clk); #1;
    chk_wb("arst_post", 1'b0, 1'b0, 5'd0, 2'd0);
    @(negedge clk); drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b0); #1;
    chk_acc("arst_grant", 1'b1, 1'b0);
    @(negedge clk); idle(); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
